// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per cycle, LSB first.
// Results land WIDTH+1 cycles after an accepted start; start is ignored while busy.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] partial;
   logic [CW-1:0]    cnt;
   logic             br;

   logic a0, b0, d_bit, br_nxt;
   assign a0     = a_sh[0];
   assign b0     = b_sh[0];
   assign d_bit  = a0 ^ b0 ^ br;
   assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         partial <= '0;
         cnt     <= '0;
         br      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         borrow  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  br    <= bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               // Result bits enter at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
               partial <= {d_bit, partial[WIDTH-1:1]};
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               br      <= br_nxt;
               cnt     <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  busy  <= 1'b0;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               diff   <= partial;
               borrow <= br;
               done   <= 1'b1;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  br    <= bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
